// File: rtl/pc88_ldr_bridge_if.sv
// Signal bundle between hps_io (ioctl download stream), the loader bridge and the
// PC-8801 core LOADER_* port. The bridge uses the slave modport.
interface pc88_ldr_bridge_if #(
  parameter int ADR_W = 19
);
  logic             ioctl_download;
  logic             ioctl_wr;
  logic [ADR_W-1:0] ioctl_addr;
  logic [7:0]       ioctl_dout;
  logic             ioctl_wait;
  logic             ldr_oe;
  logic [ADR_W-1:0] ldr_adr;
  logic [7:0]       ldr_wdat;
  logic             ldr_wr;
  logic             ldr_ack;
  logic             ldr_done;
  logic             ldr_ovf;
  logic [15:0]      ldr_sum;

  // Master is the surrounding world: HPS stream source plus the core acknowledging writes.
  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ldr_ack,
    input  ioctl_wait, ldr_oe, ldr_adr, ldr_wdat, ldr_wr, ldr_done, ldr_ovf, ldr_sum
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ldr_ack,
    output ioctl_wait, ldr_oe, ldr_adr, ldr_wdat, ldr_wr, ldr_done, ldr_ovf, ldr_sum
  );
endinterface

// File: rtl/pc88_ldr_bridge.sv
// Buffered bridge from the HPS ioctl download stream to the PC-8801 LOADER_* port.
// Optional feature: define PC88_LDR_CHKSUM_EN to build the ldr_sum checksum accumulator.
module pc88_ldr_bridge #(
  parameter int DEPTH = 8,
  parameter int ADR_W = 19
) (
  input  logic             clk21m,
  input  logic             rstn,
  pc88_ldr_bridge_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = ADR_W + 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [FW-1:0]    mem [DEPTH];
  logic [FW-1:0]    head;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_nxt;
  logic             dl_q, ack_q;
  logic             full, empty;
  logic             push, pop, drop, issue;
  logic             oe, done;
  logic             wr_q, wait_q, ovf_q;
  logic [ADR_W-1:0] adr_q;
  logic [7:0]       wdat_q;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  assign push  = bus.ioctl_wr & ~done & ~full;
  assign drop  = bus.ioctl_wr & ~done & full;
  // Completion is the ack rising edge, so a held-high ack can never retire two writes.
  assign pop   = wr_q & bus.ldr_ack & ~ack_q;
  assign issue = ~wr_q & ~empty & ~bus.ldr_ack;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    state_nxt = state;
    oe        = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.ioctl_download & ~dl_q) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        oe = 1'b1;
        if (~bus.ioctl_download & dl_q) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        oe = 1'b1;
        if (empty & ~wr_q) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk21m or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      dl_q   <= 1'b0;
      ack_q  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wait_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      dl_q   <= bus.ioctl_download;
      ack_q  <= bus.ldr_ack;
      count  <= count_nxt;
      // Asserted one entry early so a strobe already in flight still finds a free slot.
      wait_q <= (count_nxt >= CW'(DEPTH - 1));
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (drop) ovf_q  <= 1'b1;
    end
  end

  // NOTE: the FIFO storage has no reset; only pointers and count decide which entries are valid.
  always_ff @(posedge clk21m) begin
    if (push) mem[wr_ptr] <= {bus.ioctl_addr, bus.ioctl_dout};
  end

  // Head stays in the FIFO until its write completes; adr/wdat are frozen while ldr_wr is high.
  always_ff @(posedge clk21m or negedge rstn) begin
    if (!rstn) begin
      wr_q   <= 1'b0;
      adr_q  <= '0;
      wdat_q <= '0;
    end else if (issue) begin
      wr_q   <= 1'b1;
      adr_q  <= head[FW-1:8];
      wdat_q <= head[7:0];
    end else if (pop) begin
      wr_q   <= 1'b0;
    end
  end

`ifdef PC88_LDR_CHKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk21m or negedge rstn) begin
    if (!rstn)    sum_q <= '0;
    else if (pop) sum_q <= sum_q + {8'h00, wdat_q};
  end

  assign bus.ldr_sum = sum_q;
`else
  assign bus.ldr_sum = 16'h0000;
`endif

  assign bus.ioctl_wait = wait_q;
  assign bus.ldr_oe     = oe;
  assign bus.ldr_done   = done;
  assign bus.ldr_ovf    = ovf_q;
  assign bus.ldr_wr     = wr_q;
  assign bus.ldr_adr    = adr_q;
  assign bus.ldr_wdat   = wdat_q;
endmodule

// File: tb/tb_pc88_ldr_bridge.sv
// Self-checking bench for pc88_ldr_bridge: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized downloads.
module tb_pc88_ldr_bridge;
  localparam int DEPTH = 8;
  localparam int ADR_W = 19;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [7:0]       dat;
  } wr_t;

`ifdef PC88_LDR_CHKSUM_EN
  localparam logic [15:0] SUM_A5 = 16'h00A5;
`else
  localparam logic [15:0] SUM_A5 = 16'h0000;
`endif

  logic clk21m = 1'b0;
  logic rstn   = 1'b0;
  always #5 clk21m = ~clk21m;

  pc88_ldr_bridge_if #(.ADR_W(ADR_W)) bus ();

  pc88_ldr_bridge #(.DEPTH(DEPTH), .ADR_W(ADR_W)) dut (
    .clk21m (clk21m),
    .rstn   (rstn),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a queue plus a few flags ----------------
  wr_t         m_q[$];
  wr_t         m_log[$];
  wr_t         m_cur;
  bit          m_wr, m_ack_prev, m_dl_prev, m_ovf, m_wait;
  bit          m_started, m_closed, m_done;
  logic [15:0] m_sum;

  always @(posedge clk21m or negedge rstn) begin
    int n;
    bit rise, fall, cmpl, iss, accept, go_done;
    if (!rstn) begin
      m_q.delete();
      m_cur = '0; m_wr = 0; m_ack_prev = 0; m_dl_prev = 0;
      m_ovf = 0; m_wait = 0; m_started = 0; m_closed = 0; m_done = 0; m_sum = '0;
    end else begin
      n       = m_q.size();
      rise    = bus.ioctl_download && !m_dl_prev;
      fall    = !bus.ioctl_download && m_dl_prev;
      accept  = bus.ioctl_wr && !m_done && (n < DEPTH);
      cmpl    = m_wr && bus.ldr_ack && !m_ack_prev;
      iss     = !m_wr && (n > 0) && !bus.ldr_ack;
      go_done = m_closed && !m_done && (n == 0) && !m_wr;
      if (bus.ioctl_wr && !m_done && n == DEPTH) m_ovf = 1;
      if (!m_started && rise) m_started = 1;
      else if (m_started && !m_closed && fall) m_closed = 1;
      if (cmpl) begin
        m_wr  = 0;
        m_sum = m_sum + {8'h00, m_cur.dat};
        m_log.push_back(m_cur);
        void'(m_q.pop_front());
      end
      if (iss) begin
        m_cur = m_q[0];
        m_wr  = 1;
      end
      if (accept) m_q.push_back({bus.ioctl_addr, bus.ioctl_dout});
      if (go_done) m_done = 1;
      m_wait     = (m_q.size() >= DEPTH - 1);
      m_ack_prev = bus.ldr_ack;
      m_dl_prev  = bus.ioctl_download;
    end
  end

  // ---------------- compare process + observed write log ----------------
  wr_t d_log[$];
  bit  d_ack_prev;

  always @(negedge clk21m) begin
    logic [15:0] exp_sum;
`ifdef PC88_LDR_CHKSUM_EN
    exp_sum = m_sum;
`else
    exp_sum = 16'h0000;
`endif
    if (rstn) begin
      check("ldr_wr",     32'(bus.ldr_wr),     32'(m_wr));
      check("ldr_adr",    32'(bus.ldr_adr),    32'(m_cur.adr));
      check("ldr_wdat",   32'(bus.ldr_wdat),   32'(m_cur.dat));
      check("ldr_oe",     32'(bus.ldr_oe),     32'(m_started && !m_done));
      check("ldr_done",   32'(bus.ldr_done),   32'(m_done));
      check("ldr_ovf",    32'(bus.ldr_ovf),    32'(m_ovf));
      check("ioctl_wait", 32'(bus.ioctl_wait), 32'(m_wait));
      check("ldr_sum",    32'(bus.ldr_sum),    32'(exp_sum));
      if (bus.ldr_wr && bus.ldr_ack && !d_ack_prev) d_log.push_back({bus.ldr_adr, bus.ldr_wdat});
      d_ack_prev = bus.ldr_ack;
    end else begin
      d_ack_prev = 0;
    end
  end

  // ---------------- core-side ack responder ----------------
  int ack_delay = 1;
  int ack_len   = 1;
  bit ack_block = 0;
  int ack_cnt, ack_left;

  always @(posedge clk21m) begin
    #1;
    if (!rstn) begin
      bus.ldr_ack = 1'b0; ack_cnt = 0; ack_left = 0;
    end else if (ack_left > 0) begin
      ack_left--;
      if (ack_left == 0) bus.ldr_ack = 1'b0;
    end else if (bus.ldr_wr && !ack_block) begin
      ack_cnt++;
      if (ack_cnt >= ack_delay) begin
        bus.ldr_ack = 1'b1; ack_left = ack_len; ack_cnt = 0;
      end
    end else begin
      ack_cnt = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk21m);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.ioctl_download = 1'b0; bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0; bus.ioctl_dout = '0;
    ack_block = 0; ack_delay = 1; ack_len = 1;
    tick(); tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic strobe(input logic [ADR_W-1:0] a, input logic [7:0] d);
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = a; bus.ioctl_dout = d;
    tick();
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!bus.ldr_done && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(bus.ldr_done), 32'd1);
  endtask

  task automatic check_log(input int base, input wr_t exp[$], input string name);
    check({name, "_count"}, 32'(d_log.size() - base), 32'(exp.size()));
    for (int i = 0; i < exp.size() && base + i < d_log.size(); i++) begin
      check({name, "_adr"}, 32'(d_log[base+i].adr), 32'(exp[i].adr));
      check({name, "_dat"}, 32'(d_log[base+i].dat), 32'(exp[i].dat));
    end
  endtask

  // ---------------- directed scenarios ----------------
  task automatic run_single_and_post_done();
    int base, wr_seen;
    do_reset();
    check("rst_wr",   32'(bus.ldr_wr),     32'd0);
    check("rst_oe",   32'(bus.ldr_oe),     32'd0);
    check("rst_done", 32'(bus.ldr_done),   32'd0);
    check("rst_wait", 32'(bus.ioctl_wait), 32'd0);
    check("rst_adr",  32'(bus.ldr_adr),    32'd0);
    ack_delay = 3;
    bus.ioctl_download = 1'b1;
    tick();
    base = d_log.size();
    strobe(19'h00010, 8'hA5);
    bus.ioctl_download = 1'b0;
    check("single_c1_wr", 32'(bus.ldr_wr), 32'd0);
    tick();
    check("single_c2_wr",   32'(bus.ldr_wr),   32'd1);
    check("single_c2_adr",  32'(bus.ldr_adr),  32'h00010);
    check("single_c2_wdat", 32'(bus.ldr_wdat), 32'hA5);
    wait_done(50, "single_done");
    check("single_sum",   32'(bus.ldr_sum), 32'(SUM_A5));
    check("model_sum",    32'(m_sum),       32'h00A5);
    check("single_count", 32'(d_log.size() - base), 32'd1);
    // A second download after done must be ignored entirely.
    bus.ioctl_download = 1'b1;
    tick();
    wr_seen = 0;
    for (int i = 0; i < 4; i++) begin
      strobe(19'(32'h100 + i), 8'(i));
      if (bus.ldr_wr) wr_seen++;
    end
    bus.ioctl_download = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.ldr_wr) wr_seen++;
    end
    check("post_done_wr",   32'(wr_seen),      32'd0);
    check("post_done_oe",   32'(bus.ldr_oe),   32'd0);
    check("post_done_done", 32'(bus.ldr_done), 32'd1);
    check("post_done_count", 32'(d_log.size() - base), 32'd1);
  endtask

  task automatic run_backpressure();
    wr_t sent[$];
    int base, i, guard;
    bit saw_wait;
    logic [ADR_W-1:0] a0;
    logic [7:0] d;
    do_reset();
    ack_delay = 10;
    bus.ioctl_download = 1'b1;
    tick();
    base = d_log.size(); a0 = 19'($urandom); i = 0; guard = 0; saw_wait = 0;
    while (i < 16 && guard < 1000) begin
      if (bus.ioctl_wait) begin
        saw_wait = 1;
        tick();
      end else begin
        d = 8'($urandom);
        sent.push_back({a0 + 19'(i), d});
        strobe(a0 + 19'(i), d);
        i++;
      end
      guard++;
    end
    check("bp_sent", 32'(i), 32'd16);
    check("bp_saw_wait", 32'(saw_wait), 32'd1);
    bus.ioctl_download = 1'b0;
    wait_done(1000, "bp_done");
    check("bp_ovf", 32'(bus.ldr_ovf), 32'd0);
    check_log(base, sent, "bp_log");
  endtask

  task automatic run_overflow();
    wr_t sent[$];
    int base;
    logic [7:0] d;
    do_reset();
    ack_block = 1;
    bus.ioctl_download = 1'b1;
    tick();
    base = d_log.size();
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      if (i < DEPTH) sent.push_back({19'(32'h2000 + i), d});
      strobe(19'(32'h2000 + i), d);
    end
    check("ovf_flag", 32'(bus.ldr_ovf),    32'd1);
    check("ovf_wait", 32'(bus.ioctl_wait), 32'd1);
    ack_block = 0; ack_delay = 2;
    bus.ioctl_download = 1'b0;
    wait_done(500, "ovf_done");
    check_log(base, sent, "ovf_log");
  endtask

  task automatic run_stuck_ack();
    int base, n, wr_during;
    do_reset();
    ack_delay = 2; ack_len = 6;
    bus.ioctl_download = 1'b1;
    tick();
    base = d_log.size();
    for (int i = 0; i < 3; i++) strobe(19'(32'h300 + i), 8'(8'h30 + i));
    n = 0;
    while (!bus.ldr_ack && n < 50) begin
      tick();
      n++;
    end
    check("stuck_ack_seen", 32'(bus.ldr_ack), 32'd1);
    n = 0; wr_during = 0;
    while (bus.ldr_ack && n < 20) begin
      tick();
      if (bus.ldr_ack && bus.ldr_wr) wr_during++;
      n++;
    end
    check("stuck_no_rewrite", 32'(wr_during), 32'd0);
    check("stuck_one_pop", 32'(d_log.size() - base), 32'd1);
    bus.ioctl_download = 1'b0;
    wait_done(300, "stuck_done");
    check("stuck_count", 32'(d_log.size() - base), 32'd3);
  endtask

  task automatic run_reset_mid_load();
    int wr_seen;
    do_reset();
    ack_block = 1;
    bus.ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) strobe(19'(32'h400 + i), 8'(8'h40 + i));
    check("rml_pre_wr", 32'(bus.ldr_wr), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("rml_wr",   32'(bus.ldr_wr),     32'd0);
    check("rml_oe",   32'(bus.ldr_oe),     32'd0);
    check("rml_adr",  32'(bus.ldr_adr),    32'd0);
    check("rml_wdat", 32'(bus.ldr_wdat),   32'd0);
    check("rml_done", 32'(bus.ldr_done),   32'd0);
    check("rml_ovf",  32'(bus.ldr_ovf),    32'd0);
    check("rml_wait", 32'(bus.ioctl_wait), 32'd0);
    check("rml_sum",  32'(bus.ldr_sum),    32'd0);
    bus.ioctl_download = 1'b0;
    tick();
    rstn = 1'b1; ack_block = 0;
    wr_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.ldr_wr) wr_seen++;
    end
    check("rml_empty_no_wr", 32'(wr_seen), 32'd0);
    bus.ioctl_download = 1'b1;
    tick();
    bus.ioctl_download = 1'b0;
    tick();
    check("rml_done_c1", 32'(bus.ldr_done), 32'd0);
    tick();
    check("rml_done_c2", 32'(bus.ldr_done), 32'd1);
  endtask

  // ---------------- randomized downloads ----------------
  task automatic run_random(input int iters);
    int n, sent, guard, base_d, base_m;
    bit honor;
    for (int it = 0; it < iters; it++) begin
      do_reset();
      ack_delay = int'($urandom_range(1, 6));
      ack_len   = int'($urandom_range(1, 3));
      honor     = ($urandom_range(0, 3) != 0);
      bus.ioctl_download = 1'b1;
      tick();
      base_d = d_log.size(); base_m = m_log.size();
      n = int'($urandom_range(1, 20)); sent = 0; guard = 0;
      while (sent < n && guard < 400) begin
        if ($urandom_range(0, 1) == 1 && !(honor && bus.ioctl_wait)) begin
          sent++;
          if (sent == n && $urandom_range(0, 1) == 1) bus.ioctl_download = 1'b0;
          strobe(19'($urandom), 8'($urandom));
        end else begin
          tick();
        end
        guard++;
      end
      bus.ioctl_download = 1'b0;
      wait_done(800, "rnd_done");
      check_log(base_d, m_log[base_m:$], "rnd_log");
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    run_single_and_post_done();
    run_backpressure();
    run_overflow();
    run_stuck_ack();
    run_reset_mid_load();
    run_random(30);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
